// File: rtl/sseg_scan_decoder.sv
// Passive monitor for a multiplexed seven-segment bus: waits for a stable
// anode/cathode pattern, decodes it to hex and assembles full frames.
module sseg_scan_decoder #(
  parameter int N_DIG      = 8,
  parameter int STABLE_CYC = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_DIG-1:0]   an,
  input  logic [7:0]         sseg,
  input  logic               clear,
  output logic [4*N_DIG-1:0] hex_out,
  output logic [N_DIG-1:0]   dp_out,
  output logic [N_DIG-1:0]   digit_valid,
  output logic               frame_stb,
  output logic               frame_valid,
  output logic               err_pattern,
  output logic               err_anode
);

  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;

  // Returns {legal, value} for an active-low gfedcba pattern.
  function automatic logic [4:0] seg_decode(input logic [6:0] p);
    logic [4:0] d;
    d = 5'b0;
    case (p)
      7'h40: d = {1'b1, 4'h0};
      7'h79: d = {1'b1, 4'h1};
      7'h24: d = {1'b1, 4'h2};
      7'h30: d = {1'b1, 4'h3};
      7'h19: d = {1'b1, 4'h4};
      7'h12: d = {1'b1, 4'h5};
      7'h02: d = {1'b1, 4'h6};
      7'h78: d = {1'b1, 4'h7};
      7'h00: d = {1'b1, 4'h8};
      7'h10: d = {1'b1, 4'h9};
      7'h08: d = {1'b1, 4'hA};
      7'h03: d = {1'b1, 4'hB};
      7'h46: d = {1'b1, 4'hC};
      7'h21: d = {1'b1, 4'hD};
      7'h06: d = {1'b1, 4'hE};
      7'h0E: d = {1'b1, 4'hF};
      default: d = 5'b0;
    endcase
    return d;
  endfunction

  logic [N_DIG+7:0] r;
  logic [N_DIG+7:0] nxt;
  logic [CW-1:0]    cnt;
  logic [N_DIG-1:0] seen;
  logic [N_DIG-1:0] low;
  logic             same;
  logic             cap;
  logic             blank;
  logic             multi;
  logic             legal;
  logic [3:0]       val;
  logic [IW-1:0]    idx;

  assign nxt   = {an, sseg};
  assign same  = (nxt == r);
  assign cap   = same && (cnt == CW'(STABLE_CYC - 1));
  assign low   = ~r[N_DIG+7:8];
  assign blank = (low == '0);
  assign multi = ((low & (low - N_DIG'(1))) != '0);
  assign {legal, val} = seg_decode(r[6:0]);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_DIG; i++)
      if (low[i]) idx = IW'(i);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r           <= '1;
      cnt         <= '0;
      seen        <= '0;
      hex_out     <= '0;
      dp_out      <= '0;
      digit_valid <= '0;
      frame_stb   <= 1'b0;
      frame_valid <= 1'b0;
      err_pattern <= 1'b0;
      err_anode   <= 1'b0;
    end else begin
      r <= nxt;
      if (!same)
        cnt <= '0;
      else if (cnt != CW'(STABLE_CYC))
        cnt <= cnt + CW'(1);
      frame_stb <= 1'b0;
      if (clear) begin
        seen        <= '0;
        hex_out     <= '0;
        dp_out      <= '0;
        digit_valid <= '0;
        frame_valid <= 1'b0;
        err_pattern <= 1'b0;
        err_anode   <= 1'b0;
      end else if (cap && !blank) begin
        if (multi) begin
          err_anode <= 1'b1;
          seen      <= '0;
        end else if (legal) begin
          hex_out[{idx, 2'b00} +: 4] <= val;
          dp_out[idx]      <= ~r[7];
          digit_valid[idx] <= 1'b1;
          // The completing capture restarts the seen mask for the next frame.
          if ((seen | low) == '1) begin
            seen        <= '0;
            frame_stb   <= 1'b1;
            frame_valid <= 1'b1;
          end else begin
            seen <= seen | low;
          end
        end else begin
          err_pattern      <= 1'b1;
          digit_valid[idx] <= 1'b0;
          seen             <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed self-checking bench for sseg_scan_decoder: capture timing,
// frame assembly, error flags, clear collision and mid-frame reset.
module tb_sseg_scan_decoder;

  logic        clk;
  logic        reset_n;
  logic [7:0]  an;
  logic [7:0]  sseg;
  logic        clear;
  logic [31:0] hex_out;
  logic [7:0]  dp_out;
  logic [7:0]  digit_valid;
  logic        frame_stb;
  logic        frame_valid;
  logic        err_pattern;
  logic        err_anode;

  int pass;
  int total;
  int stb_cnt;
  logic [6:0] segs [16];

  sseg_scan_decoder #(.N_DIG(8), .STABLE_CYC(4)) dut (
    .clk(clk), .reset_n(reset_n), .an(an), .sseg(sseg), .clear(clear),
    .hex_out(hex_out), .dp_out(dp_out), .digit_valid(digit_valid),
    .frame_stb(frame_stb), .frame_valid(frame_valid),
    .err_pattern(err_pattern), .err_anode(err_anode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk)
    if (frame_stb === 1'b1) stb_cnt++;

  function automatic logic [7:0] an_sel(input int i);
    logic [7:0] one;
    one = 8'h01;
    return ~(one << i);
  endfunction

  task automatic hold(input logic [7:0] a, input logic [7:0] s, input int n);
    an = a;
    sseg = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; clear = 1'b0; an = '1; sseg = '1;
    repeat (3) @(negedge clk);
    total++;
    if (hex_out !== 32'h0)
      $display("FAIL reset_hex: got %h want %h", hex_out, 32'h0);
    else pass++;
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if ({dp_out, digit_valid, frame_stb, frame_valid, err_pattern, err_anode} !== 20'h0)
      $display("FAIL reset_flags: got %h want %h",
        {dp_out, digit_valid, frame_stb, frame_valid, err_pattern, err_anode}, 20'h0);
    else pass++;
  endtask

  task automatic test_single;
    hold(an_sel(0), {1'b1, segs[2]}, 4);
    total++;
    if (digit_valid !== 8'h00)
      $display("FAIL single_early: got %h want %h", digit_valid, 8'h00);
    else pass++;
    @(negedge clk);
    total++;
    if ({hex_out[3:0], digit_valid, dp_out} !== {4'h2, 8'h01, 8'h00})
      $display("FAIL single_cap: got %h want %h",
        {hex_out[3:0], digit_valid, dp_out}, {4'h2, 8'h01, 8'h00});
    else pass++;
    repeat (3) @(negedge clk);
    total++;
    if ({hex_out[3:0], digit_valid, frame_stb} !== {4'h2, 8'h01, 1'b0})
      $display("FAIL single_hold: got %h want %h",
        {hex_out[3:0], digit_valid, frame_stb}, {4'h2, 8'h01, 1'b0});
    else pass++;
  endtask

  task automatic test_frame;
    int s0;
    s0 = stb_cnt;
    for (int d = 0; d < 8; d++) begin
      hold(an_sel(d), {1'b1, segs[d]}, 5);
      if (d == 7) begin
        total++;
        if (frame_stb !== 1'b1)
          $display("FAIL frame_stb_hi: got %b want %b", frame_stb, 1'b1);
        else pass++;
      end
      @(negedge clk);
      if (d == 7) begin
        total++;
        if (frame_stb !== 1'b0)
          $display("FAIL frame_stb_lo: got %b want %b", frame_stb, 1'b0);
        else pass++;
      end
    end
    total++;
    if (hex_out !== 32'h76543210)
      $display("FAIL frame_hex: got %h want %h", hex_out, 32'h76543210);
    else pass++;
    total++;
    if ({frame_valid, digit_valid, dp_out} !== {1'b1, 8'hFF, 8'h00})
      $display("FAIL frame_flags: got %h want %h",
        {frame_valid, digit_valid, dp_out}, {1'b1, 8'hFF, 8'h00});
    else pass++;
    total++;
    if (stb_cnt - s0 !== 1)
      $display("FAIL frame_stb_count: got %0d want %0d", stb_cnt - s0, 1);
    else pass++;
  endtask

  task automatic test_bad_pattern;
    int s0;
    hold(an_sel(2), 8'h7F, 6);
    total++;
    if ({err_pattern, digit_valid} !== {1'b1, 8'hFB})
      $display("FAIL badpat_flags: got %h want %h",
        {err_pattern, digit_valid}, {1'b1, 8'hFB});
    else pass++;
    total++;
    if ({hex_out, dp_out} !== {32'h76543210, 8'h00})
      $display("FAIL badpat_keep: got %h want %h",
        {hex_out, dp_out}, {32'h76543210, 8'h00});
    else pass++;
    s0 = stb_cnt;
    for (int d = 0; d < 8; d++)
      if (d != 2) hold(an_sel(d), {d != 5, segs[15-d]}, 6);
    total++;
    if (stb_cnt - s0 !== 0)
      $display("FAIL badpat_restart: got %0d want %0d", stb_cnt - s0, 0);
    else pass++;
    hold(an_sel(2), {1'b1, segs[13]}, 6);
    total++;
    if (stb_cnt - s0 !== 1)
      $display("FAIL badpat_frame: got %0d want %0d", stb_cnt - s0, 1);
    else pass++;
    total++;
    if ({hex_out, dp_out, digit_valid} !== {32'h89ABCDEF, 8'h20, 8'hFF})
      $display("FAIL badpat_hex: got %h want %h",
        {hex_out, dp_out, digit_valid}, {32'h89ABCDEF, 8'h20, 8'hFF});
    else pass++;
  endtask

  task automatic test_bad_anode;
    hold(8'hFC, {1'b1, segs[1]}, 6);
    total++;
    if ({err_anode, hex_out} !== {1'b1, 32'h89ABCDEF})
      $display("FAIL badan: got %h want %h",
        {err_anode, hex_out}, {1'b1, 32'h89ABCDEF});
    else pass++;
  endtask

  task automatic test_short;
    hold(an_sel(0), {1'b1, segs[4]}, 3);
    hold(an_sel(1), {1'b1, segs[4]}, 4);
    hold(8'hFF, 8'hFF, 6);
    total++;
    if ({hex_out, digit_valid} !== {32'h89ABCDEF, 8'hFF})
      $display("FAIL short_ignored: got %h want %h",
        {hex_out, digit_valid}, {32'h89ABCDEF, 8'hFF});
    else pass++;
  endtask

  task automatic test_clear_collision;
    int s0;
    s0 = stb_cnt;
    for (int d = 0; d < 7; d++) hold(an_sel(d), {1'b1, segs[d]}, 6);
    hold(an_sel(7), {1'b1, segs[7]}, 4);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    total++;
    if (frame_stb !== 1'b0)
      $display("FAIL clr_stb: got %b want %b", frame_stb, 1'b0);
    else pass++;
    total++;
    if ({hex_out, dp_out, digit_valid, frame_valid, err_pattern, err_anode} !== 51'h0)
      $display("FAIL clr_outs: got %h want %h",
        {hex_out, dp_out, digit_valid, frame_valid, err_pattern, err_anode}, 51'h0);
    else pass++;
    repeat (3) @(negedge clk);
    total++;
    if ({stb_cnt - s0, hex_out} !== {32'd0, 32'h0})
      $display("FAIL clr_after: got %h want %h", {stb_cnt - s0, hex_out}, 64'h0);
    else pass++;
  endtask

  task automatic test_reset_midframe;
    int s0;
    for (int d = 0; d < 4; d++) hold(an_sel(d), {1'b1, segs[8+d]}, 6);
    an = '1; sseg = '1; reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({hex_out, dp_out, digit_valid, frame_stb, frame_valid, err_pattern, err_anode} !== 52'h0)
      $display("FAIL rst_mid: got %h want %h",
        {hex_out, dp_out, digit_valid, frame_stb, frame_valid, err_pattern, err_anode}, 52'h0);
    else pass++;
    reset_n = 1'b1;
    s0 = stb_cnt;
    for (int d = 4; d < 8; d++) hold(an_sel(d), {1'b1, segs[d]}, 6);
    total++;
    if (stb_cnt - s0 !== 0)
      $display("FAIL rst_half: got %0d want %0d", stb_cnt - s0, 0);
    else pass++;
    for (int d = 0; d < 4; d++) hold(an_sel(d), {1'b1, segs[d]}, 6);
    hold(8'hFF, 8'hFF, 2);
    total++;
    if ({stb_cnt - s0, hex_out} !== {32'd1, 32'h76543210})
      $display("FAIL rst_full: got %h want %h",
        {stb_cnt - s0, hex_out}, {32'd1, 32'h76543210});
    else pass++;
  endtask

  initial begin
    pass = 0;
    total = 0;
    stb_cnt = 0;
    segs = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    test_reset;
    test_single;
    test_frame;
    test_bad_pattern;
    test_bad_anode;
    test_short;
    test_clear_collision;
    test_reset_midframe;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule

// File: doc/sseg_scan_decoder.md
Name: sseg_scan_decoder

Overview:
- Passive monitor on a multiplexed seven-segment display bus (active-low anodes, active-low cathodes, gfedcba order plus dp).
- Waits for each anode/cathode pattern to be stable, then decodes the pattern back to its 4-bit hex value.
- Assembles one full display frame into a parallel word and flags illegal patterns or anode states.
- Used in-system for self-check and readback of the display driver's output.

Parameters:
- N_DIG, 8, number of digits / anode lines.
- STABLE_CYC, 4, clock edges a registered {an, sseg} value must stay unchanged before it is captured; must be at least 1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous, active-low reset.
- an  in  N_DIG  anode selects, active-low, expected one-hot-low or all ones (blank).
- sseg  in  8  cathodes, active-low, {dp,g,f,e,d,c,b,a}.
- clear  in  1  synchronous clear of captured data and flags.
- hex_out  out  4*N_DIG  decoded digits; digit i is at [4i+3:4i].
- dp_out  out  N_DIG  decoded decimal points, active-high.
- digit_valid  out  N_DIG  digit i holds a legal decoded value.
- frame_stb  out  1  one-cycle pulse when every digit has been captured legally since the last frame.
- frame_valid  out  1  sticky; at least one complete frame has been captured.
- err_pattern  out  1  sticky; an illegal cathode pattern was captured.
- err_anode  out  1  sticky; more than one anode was low in a stable period.

Behaviour:
- Input stage: r <= {an, sseg} every edge. On reset, r is all ones (blank), so reset produces no spurious capture.
- Stability counter cnt, saturating at STABLE_CYC:
  - Edge where r loads a value different from its current value: cnt <= 0.
  - Otherwise: cnt increments.
- Capture event: the edge where cnt == STABLE_CYC-1 and r is unchanged. Exactly one capture per stable period, with no recapture until the value changes.
- Timing: if a value is first presented before edge E0, the capture and all output updates occur at E0+STABLE_CYC. Any value held for fewer than STABLE_CYC+1 edges is ignored.
- Capture classification, in priority order:
  1. an all ones: no action.
  2. More than one an bit low: err_anode <= 1. No digit update. Seen mask cleared.
  3. Exactly an[i] low: decode sseg[6:0] per the table below.
- Decode table, pattern (hex, gfedcba) -> value:
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
- Legal pattern: hex_out digit i <= value, dp_out[i] <= ~sseg[7], digit_valid[i] <= 1, seen[i] <= 1.
- Illegal pattern: err_pattern <= 1, digit_valid[i] <= 0, hex_out digit i and dp_out[i] unchanged, seen mask cleared (frame restarts).
- Frame completion:
  - The capture that makes seen all ones also clears seen to zero in the same edge.
  - frame_stb is high for the one cycle after that edge.
  - frame_valid <= 1 at that edge.
  - Digits can arrive in any order; repeat captures of an already-seen digit only refresh its value.
- clear:
  - Zeroes hex_out, dp_out, digit_valid, seen, frame_valid, err_pattern and err_anode; suppresses frame_stb.
  - Does not touch r or cnt.
  - clear wins over a capture in the same cycle; that capture is discarded.
- Reset values: all outputs 0; seen = 0; cnt = 0; r = all ones.
- Reset asserted mid-frame discards partial frame state.

Test Plan:
- Reset, then hold an=11111110, sseg=0x24 for 6 cycles -> at E0+4: hex_out[3:0]=2, digit_valid=0x01, dp_out=0. No further update while the value is held.
- Scan 8 digits with sseg values 40,79,24,30,19,12,02,78 at 6 cycles each -> hex_out=0x76543210, frame_stb high exactly 1 cycle after the 8th capture, frame_valid=1, digit_valid=0xFF.
- Present an=11111011, sseg=0x7F (dp on, illegal segments) -> err_pattern=1, digit_valid[2]=0, hex_out digit 2 unchanged. The next frame requires all 8 digits again before frame_stb.
- Hold an=11111100 for 6 cycles -> err_anode=1, no hex_out change. Hold a legal digit for only 3 cycles, STABLE_CYC-1 -> no capture.
- Assert clear on the same edge as the capture completing a frame -> no frame_stb, all outputs 0. Assert reset_n=0 mid-frame -> all outputs 0, and a following full scan produces exactly one frame_stb.
